// File: rtl/shift_pipe_sched.sv
// shift_pipe_sched: round-robin scheduler sharing one fixed-latency pipe among
// NumReq requesters. Granted beats go out through a registered issue stage, and
// a parallel ID shift register follows each beat through the pipe. Returning
// beats are routed to their owner by that ID. Per-requester credit counters
// bound the number of outstanding beats. A sticky flag reports when the pipe and
// the tracker disagree.
module shift_pipe_sched #(
    parameter int NumReq   = 4,
    parameter int Width    = 32,
    parameter int Latency  = 8,
    parameter int MaxOutst = 4,
    localparam int IdW     = $clog2(NumReq),
    localparam int CntW    = $clog2(MaxOutst + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq*Width-1:0] req_data_i,
    output logic                    pipe_valid_o,
    output logic [Width-1:0]        pipe_data_o,
    input  logic                    pipe_valid_i,
    input  logic [Width-1:0]        pipe_data_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    output logic [Width-1:0]        rsp_data_o,
    output logic                    busy_o,
    output logic                    err_o
);

    // Scheduler state
    logic [IdW-1:0]   ptr_reg;
    logic [CntW-1:0]  cnt_reg  [NumReq];
    logic [CntW-1:0]  cnt_next [NumReq];
    logic             pipe_valid_reg;
    logic [Width-1:0] pipe_data_reg;
    logic             err_reg;

    // ID tracker: stage Latency is the tail and lines up with pipe_valid_i.
    logic [Latency:0] trk_valid_reg;
    logic [IdW-1:0]   trk_id_reg  [Latency+1];
    logic [IdW-1:0]   trk_id_next [Latency+1];

    // Arbitration and response signals
    logic [NumReq-1:0] elig;
    logic [NumReq-1:0] grant;
    logic [IdW-1:0]    grant_id;
    logic              grant_any;
    logic [Width-1:0]  granted_data;
    logic              tail_valid;
    logic [IdW-1:0]    tail_id;
    logic [NumReq-1:0] rsp_hit;
    logic [NumReq-1:0] drop_hit;
    logic [NumReq-1:0] underflow;

    assign tail_valid = trk_valid_reg[Latency];
    assign tail_id    = trk_id_reg[Latency];

    // Per-requester eligibility, response decode and credit update.
    // Eligibility looks only at the registered count, so a credit returned this
    // cycle can be used from the next cycle on.
    // A tail entry with no pipe beat releases its credit so the slot is not lost.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign elig[gi] = en_i & ~rst_i & req_valid_i[gi]
                            & (cnt_reg[gi] < CntW'(MaxOutst));
            assign rsp_hit[gi]  = pipe_valid_i & tail_valid & (tail_id == IdW'(gi));
            assign drop_hit[gi] = ~pipe_valid_i & tail_valid & (tail_id == IdW'(gi));
            assign underflow[gi] = rsp_hit[gi] & (cnt_reg[gi] == '0);

            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (grant[gi] && !(rsp_hit[gi] || drop_hit[gi])) begin
                    if (cnt_reg[gi] < CntW'(MaxOutst)) begin
                        cnt_next[gi] = cnt_reg[gi] + 1'b1;
                    end
                end else if (!grant[gi] && (rsp_hit[gi] || drop_hit[gi])) begin
                    if (cnt_reg[gi] != '0) begin
                        cnt_next[gi] = cnt_reg[gi] - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin search starting just after the last granted index
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = 1; i <= NumReq; i++) begin
            if (!grant_any && elig[(int'(ptr_reg) + i) % NumReq]) begin
                grant_any = 1'b1;
                grant_id  = IdW'((int'(ptr_reg) + i) % NumReq);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign granted_data = req_data_i[grant_id*Width +: Width];

    // Tracker ID path: each stage loads only when the stage behind it is valid
    generate
        for (genvar gi = 0; gi <= Latency; gi++) begin : g_trk
            if (gi == 0) begin : g_head
                assign trk_id_next[gi] = grant_any ? grant_id : trk_id_reg[gi];
            end else begin : g_body
                assign trk_id_next[gi] = trk_valid_reg[gi-1] ? trk_id_reg[gi-1]
                                                             : trk_id_reg[gi];
            end
        end
    endgenerate

    // Tracker IDs carry no reset; the valid bits alone qualify them
    always_ff @(posedge clk_i) begin
        trk_id_reg <= trk_id_next;
    end

    // Pointer, issue stage, tracker valids, credits and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg        <= IdW'(NumReq - 1);
            pipe_valid_reg <= 1'b0;
            pipe_data_reg  <= '0;
            trk_valid_reg  <= '0;
            err_reg        <= 1'b0;
            for (int k = 0; k < NumReq; k++) begin
                cnt_reg[k] <= '0;
            end
        end else begin
            if (grant_any) begin
                ptr_reg       <= grant_id;
                pipe_data_reg <= granted_data;
            end
            pipe_valid_reg <= grant_any;
            trk_valid_reg  <= {trk_valid_reg[Latency-1:0], grant_any};
            cnt_reg        <= cnt_next;
            if ((pipe_valid_i != tail_valid) || (|underflow)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign req_ready_o  = grant;
    assign pipe_valid_o = pipe_valid_reg;
    assign pipe_data_o  = pipe_data_reg;
    assign rsp_valid_o  = rsp_hit;
    assign rsp_data_o   = pipe_data_i;
    assign busy_o       = pipe_valid_reg | (|trk_valid_reg);
    assign err_o        = err_reg;

endmodule

// File: tb/tb_shift_pipe_sched.sv
// Bench for shift_pipe_sched: directed request patterns with hand-computed
// grant sequences; every grant pushes its expected response onto a scoreboard
// that a negedge monitor drains as responses appear. A behavioural Latency-deep
// pipe closes the loop, with an injection hook for misaligned beats.
module tb_shift_pipe_sched;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 8;
    localparam int MO  = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           en_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_data_i;
    logic           pipe_valid_o;
    logic [W-1:0]   pipe_data_o;
    logic           pipe_valid_i;
    logic [W-1:0]   pipe_data_i;
    logic [N-1:0]   rsp_valid_o;
    logic [W-1:0]   rsp_data_o;
    logic           busy_o;
    logic           err_o;

    shift_pipe_sched #(
        .NumReq  (N),
        .Width   (W),
        .Latency (LAT),
        .MaxOutst(MO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .pipe_valid_o(pipe_valid_o),
        .pipe_data_o (pipe_data_o),
        .pipe_valid_i(pipe_valid_i),
        .pipe_data_i (pipe_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [N-1:0] who;
        logic [W-1:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int unsigned tag          = 0;
    logic        inject       = 1'b0;
    logic        en_cmd       = 1'b1;

    // Behavioural external pipe: LAT cycles from pipe_valid_o to pipe_valid_i
    logic         pv_sr [LAT];
    logic [W-1:0] pd_sr [LAT];

    always @(posedge clk_i) begin
        pv_sr[0] <= pipe_valid_o;
        pd_sr[0] <= pipe_data_o;
        for (int i = 1; i < LAT; i++) begin
            pv_sr[i] <= pv_sr[i-1];
            pd_sr[i] <= pd_sr[i-1];
        end
    end

    assign pipe_valid_i = pv_sr[LAT-1] | inject;
    assign pipe_data_i  = inject ? 32'hDEAD_BEEF : pd_sr[LAT-1];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest outstanding grant
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid_o), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_owner", 32'(rsp_valid_o), 32'(mon_e.who));
                check("rsp_data", rsp_data_o, mon_e.data);
            end
        end
    end

    // One cycle: drive requests after the edge, check the grant at the negedge,
    // and record the expected response of any grant.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] exp, input logic [W-1:0] fixed);
        logic [W-1:0] d [N];
        exp_t e;
        @(posedge clk_i);
        #1;
        tag++;
        en_i = en_cmd;
        for (int k = 0; k < N; k++) begin
            d[k] = (fixed != '0) ? fixed : {8'(k), 8'h5A, tag[15:0]};
            req_data_i[k*W +: W] = d[k];
        end
        req_valid_i = v;
        @(negedge clk_i);
        check("grant", 32'(req_ready_o), 32'(exp));
        for (int k = 0; k < N; k++) begin
            if (exp[k]) begin
                e.who  = exp;
                e.data = d[k];
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step('0, '0, '0);
        end
    endtask

    logic [N-1:0] rr_exp [8];
    logic [N-1:0] en_exp [5];
    logic [N-1:0] rst_exp [3];
    logic [N-1:0] cv;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_exp  = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        en_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst_exp = '{4'b0100, 4'b1000, 4'b0001};

        rst_i       = 1'b1;
        en_i        = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        repeat (12) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req_ready", 32'(req_ready_o), 32'h0);
        check("rst_pipe_valid", 32'(pipe_valid_o), 32'h0);
        check("rst_pipe_data", pipe_data_o, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle(2);

        // Single beat from requester 2, returned LAT+1 cycles after the grant
        step(4'b0100, 4'b0100, 32'hA5);
        step('0, '0, '0);
        check("issue_valid", 32'(pipe_valid_o), 32'h1);
        check("issue_data", pipe_data_o, 32'hA5);
        check("busy_inflight", 32'(busy_o), 32'h1);
        step('0, '0, '0);
        check("issue_valid_off", 32'(pipe_valid_o), 32'h0);
        check("issue_data_hold", pipe_data_o, 32'hA5);
        idle(6);
        step('0, '0, '0);
        check("busy_at_return", 32'(busy_o), 32'h1);
        step('0, '0, '0);
        check("busy_after_return", 32'(busy_o), 32'h0);

        // Round robin with all requesters valid; pointer currently at 2
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, rr_exp[i], '0);
        end
        idle(12);
        check("rr_busy_idle", 32'(busy_o), 32'h0);
        check("rr_sb_empty", 32'(sb.size()), 32'h0);

        // Credit limit on requester 1 then requester 0: 4 grants, stall until
        // the cycle after the first response, then reuse credits (also covers
        // grant and response to the same requester in the same cycle).
        for (int r = 0; r < 2; r++) begin
            cv = (r == 0) ? 4'b0010 : 4'b0001;
            for (int c = 0; c < 14; c++) begin
                step(cv, (c < 4 || c >= 10) ? cv : 4'b0000, '0);
            end
            idle(12);
            check("credit_busy_idle", 32'(busy_o), 32'h0);
        end

        // Enable dropped with 5 beats in flight
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, en_exp[i], '0);
        end
        en_cmd = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(4'b1111, 4'b0000, '0);
        end
        check("en_busy_idle", 32'(busy_o), 32'h0);
        check("en_sb_empty", 32'(sb.size()), 32'h0);
        en_cmd = 1'b1;

        // Asynchronous reset mid-burst; beats still in the external pipe are late
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, rst_exp[i], '0);
        end
        @(posedge clk_i);
        #2;
        req_valid_i = '0;
        rst_i       = 1'b1;
        #1;
        check("arst_pipe_valid", 32'(pipe_valid_o), 32'h0);
        check("arst_busy", 32'(busy_o), 32'h0);
        check("arst_req_ready", 32'(req_ready_o), 32'h0);
        sb.delete();
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step(4'b1111, 4'b0001, '0);
        idle(2);
        check("late_err_before", 32'(err_o), 32'h0);
        idle(2);
        check("late_err_set", 32'(err_o), 32'h1);
        idle(6);
        check("late_err_sticky", 32'(err_o), 32'h1);
        check("late_sb_empty", 32'(sb.size()), 32'h0);

        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        check("rst2_err", 32'(err_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Misaligned beat with an empty tracker tail
        idle(2);
        @(posedge clk_i);
        #1 inject = 1'b1;
        @(negedge clk_i);
        check("inj_no_rsp", 32'(rsp_valid_o), 32'h0);
        check("inj_err_same_cycle", 32'(err_o), 32'h0);
        @(posedge clk_i);
        #1 inject = 1'b0;
        @(negedge clk_i);
        check("inj_err_set", 32'(err_o), 32'h1);
        idle(4);
        check("inj_err_sticky", 32'(err_o), 32'h1);
        step(4'b1111, 4'b0001, '0);
        idle(10);
        check("final_err_sticky", 32'(err_o), 32'h1);
        check("final_sb_empty", 32'(sb.size()), 32'h0);
        check("final_busy", 32'(busy_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
